// File: rtl/param_up_down_counter.sv
// param_up_down_counter
//   Synchronous up/down modulo counter with parallel load, a combinational
//   terminal-count flag and a registered one-cycle boundary-event pulse.
//
//   Build option: define COUNTER_SAT_EN to make boundary steps saturate
//   (hold at MAX going up, hold at 0 going down) instead of wrapping. The
//   port list is identical in both builds.
//
// Parameters
//   WIDTH     counter bit width (2..32)
//   MAX       highest count value (1..2**WIDTH-1), default all ones
//
// Ports
//   clk       single clock, rising edge
//   rst_n     asynchronous active-low reset (count=0, wrap=0)
//   en        count enable
//   up_dn     direction: 1 = up, 0 = down
//   load      synchronous load strobe, takes priority over en
//   load_val  value to load, clamped to MAX
//   count     registered count value
//   tc        terminal count: count at the boundary for the current direction
//   wrap      registered pulse on each boundary step (wrapped or blocked)

module param_up_down_counter #(
   parameter int unsigned      WIDTH = 4,
   parameter logic [WIDTH-1:0] MAX   = {WIDTH{1'b1}}
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             up_dn,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] count,
   output logic             tc,
   output logic             wrap
);

   logic [WIDTH-1:0] count_q, count_d;
   logic             wrap_q, wrap_d;

   logic at_max;
   logic at_zero;

   assign at_max  = (count_q == MAX);
   assign at_zero = (count_q == '0);

   always_comb begin
      count_d = count_q;
      wrap_d  = 1'b0;
      if (load) begin
         count_d = (load_val > MAX) ? MAX : load_val;
      end else if (en) begin
         if (up_dn) begin
            if (at_max) begin
               wrap_d = 1'b1;
`ifdef COUNTER_SAT_EN
               count_d = MAX;
`else
               count_d = '0;
`endif
            end else begin
               // count_q < MAX <= all ones, so +1 cannot overflow WIDTH bits
               count_d = count_q + 1'b1;
            end
         end else begin
            if (at_zero) begin
               wrap_d = 1'b1;
`ifdef COUNTER_SAT_EN
               count_d = '0;
`else
               count_d = MAX;
`endif
            end else begin
               count_d = count_q - 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
         wrap_q  <= 1'b0;
      end else begin
         count_q <= count_d;
         wrap_q  <= wrap_d;
      end
   end

   assign count = count_q;
   assign wrap  = wrap_q;
   // Independent of en so the flag can be used to anticipate the boundary step
   assign tc    = up_dn ? at_max : at_zero;

endmodule
